// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction, writeback and ALU-issue signal bundle for alu_issue
//
// Groups the three signal sets that connect to alu_issue:
//   instruction in : in_valid, in_ready, ins
//   writeback      : wb_en, wb_rd, wb_data
//   ALU issue out  : out_valid, out_ready, out_a, out_b, out_op, out_rd, illegal
// master drives instructions, writebacks and out_ready; slave is the issue stage.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ins;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [4:0]  out_rd;
  logic        illegal;

  modport master (
    output in_valid, ins, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op, out_rd, illegal
  );

  modport slave (
    input  in_valid, ins, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op, out_rd, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RISC-V ALU issue stage: decode, register file read and single-entry output register
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset; clears the register file and output register
//   bus    : alu_issue_if.slave
//            in_valid/in_ready/ins         instruction handshake
//            wb_en/wb_rd/wb_data           register file write port
//            out_valid/out_ready           ALU handshake
//            out_a/out_b/out_op/out_rd     operands, op (0 AND, 1 OR, 2 ADD, 6 SUB), destination
//            illegal                       one-cycle pulse after accepting an undecodable ins
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  logic [31:0] regs [32];

  logic        valid_q;
  logic        illegal_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        legal;
  logic        use_imm;
  logic [2:0]  dec_op;
  logic        accept;

  assign opcode = bus.ins[6:0];
  assign funct3 = bus.ins[14:12];
  assign funct7 = bus.ins[31:25];
  assign rs1    = bus.ins[19:15];
  assign rs2    = bus.ins[24:20];
  assign imm    = {{20{bus.ins[31]}}, bus.ins[31:20]};

  // Same-cycle writeback is forwarded so an instruction never sees a stale value.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                   (bus.wb_en && bus.wb_rd == rs1) ? bus.wb_data : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                   (bus.wb_en && bus.wb_rd == rs2) ? bus.wb_data : regs[rs2];

  always_comb begin
    legal   = 1'b0;
    use_imm = 1'b0;
    dec_op  = 3'd0;
    case (opcode)
      OPC_R: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  begin legal = 1'b1; dec_op = 3'd2; end
            3'b111:  begin legal = 1'b1; dec_op = 3'd0; end
            3'b110:  begin legal = 1'b1; dec_op = 3'd1; end
            default: legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal  = 1'b1;
          dec_op = 3'd6;
        end
      end
      OPC_I: begin
        use_imm = 1'b1;
        case (funct3)
          3'b000:  begin legal = 1'b1; dec_op = 3'd2; end
          3'b111:  begin legal = 1'b1; dec_op = 3'd0; end
          3'b110:  begin legal = 1'b1; dec_op = 3'd1; end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Single-entry output register: room exists when empty or draining this cycle.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      op_q      <= 3'd0;
      rd_q      <= 5'd0;
    end else begin
      illegal_q <= accept && !legal;
      if (accept && legal) begin
        // Operands are snapshotted here so later writebacks cannot disturb a held op.
        valid_q <= 1'b1;
        a_q     <= rs1_val;
        b_q     <= use_imm ? imm : rs2_val;
        op_q    <= dec_op;
        rd_q    <= bus.ins[11:7];
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.illegal   = illegal_q;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_op    = op_q;
  assign bus.out_rd    = rd_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue: vector table, corner sequences, random scoreboard
module tb_alu_issue;

  logic clk;
  logic rst_n;
  alu_issue_if bus ();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    exp_t        e;
  } tv_t;

  exp_t        sbq [$];
  logic [31:0] mregs [32];
  logic        m_valid;
  logic        m_illegal;
  int          n_cmp;
  int          n_err;
  tv_t         tv [15];

  function automatic logic [31:0] rtype(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h33;
  endfunction

  function automatic logic [31:0] itype(input int imm12, input int rs1, input int f3, input int rd);
    return ((32'(imm12) & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
  endfunction

  function automatic exp_t mk_e(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic [4:0] rd);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.rd = rd;
    return e;
  endfunction

  function automatic tv_t mk_tv(input logic iv, input logic [31:0] ins, input logic we, input logic [4:0] wr,
                                input logic [31:0] wd, input exp_t e);
    tv_t t;
    t.iv = iv; t.ins = ins; t.we = we; t.wr = wr; t.wd = wd; t.e = e;
    return t;
  endfunction

  function automatic void dec(input logic [31:0] i, output logic ok, output logic [2:0] op, output logic imm);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    ok = 1'b0; op = 3'd0; imm = 1'b0;
    if (i[6:0] == 7'h33) begin
      if (f7 == 7'h00 && f3 == 3'd0) begin ok = 1'b1; op = 3'd2; end
      if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; op = 3'd6; end
      if (f7 == 7'h00 && f3 == 3'd7) begin ok = 1'b1; op = 3'd0; end
      if (f7 == 7'h00 && f3 == 3'd6) begin ok = 1'b1; op = 3'd1; end
    end else if (i[6:0] == 7'h13) begin
      imm = 1'b1;
      if (f3 == 3'd0) begin ok = 1'b1; op = 3'd2; end
      if (f3 == 3'd7) begin ok = 1'b1; op = 3'd0; end
      if (f3 == 3'd6) begin ok = 1'b1; op = 3'd1; end
    end
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx, input logic we, input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wr == idx) return wd;
    return mregs[idx];
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd6:    return a - b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // Called just after a rising edge: drive one cycle, check at the falling edge, advance the model.
  task automatic cycle(input logic iv, input logic [31:0] i, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic ordy, input logic use_tab, input exp_t tab);
    logic       ok, imm, acc, nv;
    logic [2:0] op;
    exp_t       e, f;
    bus.in_valid  = iv;
    bus.ins       = i;
    bus.wb_en     = we;
    bus.wb_rd     = wr;
    bus.wb_data   = wd;
    bus.out_ready = ordy;
    dec(i, ok, op, imm);
    acc  = iv && (!m_valid || ordy);
    e.a  = mread(i[19:15], we, wr, wd);
    e.b  = imm ? {{20{i[31]}}, i[31:20]} : mread(i[24:20], we, wr, wd);
    e.op = op;
    e.rd = i[11:7];
    if (acc && ok) sbq.push_back(use_tab ? tab : e);
    nv = (acc && ok) ? 1'b1 : (ordy ? 1'b0 : m_valid);
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || ordy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("illegal", 32'(bus.illegal), 32'(m_illegal));
    if (m_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard: got out_valid with no expected entry at %0t", $time);
      end else begin
        f = sbq[0];
        chk("out_a", bus.out_a, f.a);
        chk("out_b", bus.out_b, f.b);
        chk("out_op", 32'(bus.out_op), 32'(f.op));
        chk("out_rd", 32'(bus.out_rd), 32'(f.rd));
        chk("alu_result", alu(bus.out_a, bus.out_b, bus.out_op), alu(f.a, f.b, f.op));
        if (ordy) void'(sbq.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (we && wr != 5'd0) mregs[wr] = wd;
    m_valid   = nv;
    m_illegal = acc && !ok;
  endtask

  task automatic idle(input logic ordy);
    exp_t z;
    z = mk_e(0, 0, 0, 0);
    cycle(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, ordy, 1'b0, z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    exp_t z;
    int   kind;
    logic [31:0] ri;
    z = mk_e(0, 0, 0, 0);
    n_cmp = 0;
    n_err = 0;
    m_valid = 1'b0;
    m_illegal = 1'b0;
    for (int k = 0; k < 32; k++) mregs[k] = 32'd0;

    tv[0]  = mk_tv(0, 32'd0,                    1, 5'd1, 32'd5,      z);
    tv[1]  = mk_tv(0, 32'd0,                    1, 5'd2, 32'd3,      z);
    tv[2]  = mk_tv(1, rtype(0, 2, 1, 0, 3),     0, 5'd0, 32'd0,      mk_e(32'd5, 32'd3, 3'd2, 5'd3));
    tv[3]  = mk_tv(1, rtype(32, 2, 1, 0, 4),    0, 5'd0, 32'd0,      mk_e(32'd5, 32'd3, 3'd6, 5'd4));
    tv[4]  = mk_tv(1, itype(-1, 0, 0, 5),       0, 5'd0, 32'd0,      mk_e(32'd0, 32'hFFFF_FFFF, 3'd2, 5'd5));
    tv[5]  = mk_tv(1, rtype(0, 0, 7, 0, 6),     1, 5'd7, 32'h1234,   mk_e(32'h1234, 32'd0, 3'd2, 5'd6));
    tv[6]  = mk_tv(0, 32'd0,                    1, 5'd0, 32'hDEAD,   z);
    tv[7]  = mk_tv(1, rtype(0, 0, 0, 0, 8),     0, 5'd0, 32'd0,      mk_e(32'd0, 32'd0, 3'd2, 5'd8));
    tv[8]  = mk_tv(1, rtype(0, 2, 1, 7, 9),     0, 5'd0, 32'd0,      mk_e(32'd5, 32'd3, 3'd0, 5'd9));
    tv[9]  = mk_tv(1, rtype(0, 1, 7, 6, 10),    0, 5'd0, 32'd0,      mk_e(32'h1234, 32'd5, 3'd1, 5'd10));
    tv[10] = mk_tv(1, itype(12'h7FF, 7, 7, 11), 0, 5'd0, 32'd0,      mk_e(32'h1234, 32'h7FF, 3'd0, 5'd11));
    tv[11] = mk_tv(1, itype(12'h800, 1, 6, 12), 0, 5'd0, 32'd0,      mk_e(32'd5, 32'hFFFF_F800, 3'd1, 5'd12));
    tv[12] = mk_tv(1, 32'h0000_707F,            0, 5'd0, 32'd0,      z);
    tv[13] = mk_tv(1, rtype(32, 2, 1, 7, 3),    0, 5'd0, 32'd0,      z);
    tv[14] = mk_tv(1, itype(3, 1, 1, 3),        0, 5'd0, 32'd0,      z);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ins       = 32'd0;
    bus.wb_en     = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'd0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_out_a", bus.out_a, 32'd0);
    chk("rst_out_b", bus.out_b, 32'd0);
    chk("rst_out_op", 32'(bus.out_op), 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int t = 0; t < 15; t++)
      cycle(tv[t].iv, tv[t].ins, tv[t].we, tv[t].wr, tv[t].wd, 1'b1, 1'b1, tv[t].e);
    idle(1'b1);
    idle(1'b1);

    // Stall: held op must not see the writeback to x1; pending SUB picks it up on release.
    cycle(1, rtype(0, 2, 1, 0, 13), 0, 5'd0, 32'd0, 1'b1, 1'b0, z);
    for (int s = 0; s < 3; s++)
      cycle(1, rtype(32, 2, 1, 0, 14), 1, 5'd1, 32'h99, 1'b0, 1'b0, z);
    cycle(1, rtype(32, 2, 1, 0, 14), 0, 5'd0, 32'd0, 1'b1, 1'b0, z);
    cycle(1, rtype(0, 1, 2, 6, 17),  0, 5'd0, 32'd0, 1'b1, 1'b0, z);
    cycle(1, itype(-5, 1, 0, 18),    0, 5'd0, 32'd0, 1'b1, 1'b0, z);
    idle(1'b1);
    idle(1'b1);

    // Reset while an op is held.
    cycle(1, rtype(0, 2, 1, 0, 15), 0, 5'd0, 32'd0, 1'b1, 1'b0, z);
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_a", bus.out_a, 32'd0);
    chk("mid_rst_out_b", bus.out_b, 32'd0);
    chk("mid_rst_out_op", 32'(bus.out_op), 32'd0);
    chk("mid_rst_out_rd", 32'(bus.out_rd), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    sbq.delete();
    for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
    m_valid   = 1'b0;
    m_illegal = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1'b1);
    cycle(1, rtype(0, 2, 1, 0, 16), 0, 5'd0, 32'd0, 1'b1, 1'b1, mk_e(32'd0, 32'd0, 3'd2, 5'd16));
    cycle(1, itype(0, 31, 6, 19),   0, 5'd0, 32'd0, 1'b1, 1'b1, mk_e(32'd0, 32'd0, 3'd1, 5'd19));
    idle(1'b1);

    for (int r = 0; r < 220; r++) begin
      kind = int'($urandom_range(0, 6));
      case (kind)
        0:       ri = rtype(0,  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, int'($urandom_range(0, 31)));
        1:       ri = rtype(32, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, int'($urandom_range(0, 31)));
        2:       ri = rtype(0,  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 7, int'($urandom_range(0, 31)));
        3:       ri = rtype(0,  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 6, int'($urandom_range(0, 31)));
        4:       ri = itype(int'($urandom_range(0, 4095)), int'($urandom_range(0, 31)), 0, int'($urandom_range(0, 31)));
        5:       ri = itype(int'($urandom_range(0, 4095)), int'($urandom_range(0, 31)), 7, int'($urandom_range(0, 31)));
        default: ri = itype(int'($urandom_range(0, 4095)), int'($urandom_range(0, 31)), 6, int'($urandom_range(0, 31)));
      endcase
      cycle(logic'($urandom_range(0, 4) != 0), ri, logic'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom, logic'($urandom_range(0, 3) != 0), 1'b0, z);
    end
    idle(1'b1);
    idle(1'b1);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
